// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: ALU writebacks win the port, MDU results
// wait in a small FIFO whose head is protected from starvation by an age counter.
module wb_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [4:0]                  alu_rd,
  input  logic [31:0]                 alu_data,
  output logic                        alu_stall,
  input  logic                        mdu_valid,
  output logic                        mdu_ready,
  input  logic [4:0]                  mdu_rd,
  input  logic [31:0]                 mdu_data,
  output logic                        WE3,
  output logic [4:0]                  A3,
  output logic [31:0]                 WD3,
  output logic [31:0]                 pending,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]            rd_mem   [FIFO_DEPTH];
  logic [31:0]           data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [AGE_W-1:0]      age_q, age_d;
  logic                  stall_q, stall_d;
  logic                  we_q, we_d;
  logic [4:0]            a_q, a_d;
  logic [31:0]           wd_q, wd_d;

  logic fifo_nonempty, push, pop, alu_req;

  // Ready looks at the pre-pop count, so a full FIFO refuses even while popping.
  always_comb begin
    fifo_nonempty = (count_q != '0);
    mdu_ready     = !reset && (count_q < CNT_W'(FIFO_DEPTH));
    push          = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    alu_req       = alu_valid && !stall_q && (alu_rd != 5'd0);
    pop           = fifo_nonempty && (stall_q || !alu_req);
  end

  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    we_d    = 1'b0;
    a_d     = a_q;
    wd_d    = wd_q;
    age_d   = age_q;

    if (pop) valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;

    if (pop) begin
      we_d = 1'b1;
      a_d  = rd_mem[head_q];
      wd_d = data_mem[head_q];
    end else if (alu_req) begin
      we_d = 1'b1;
      a_d  = alu_rd;
      wd_d = alu_data;
    end

    if (!fifo_nonempty || pop) begin
      age_d = '0;
    end else if (age_q < AGE_W'(STARVE_LIMIT)) begin
      age_d = age_q + AGE_W'(1);
    end

    // The stall cycle always pops, so age clears and the stall drops next edge.
    stall_d = (age_d == AGE_W'(STARVE_LIMIT));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      age_q   <= '0;
      stall_q <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      age_q   <= age_d;
      stall_q <= stall_d;
      we_q    <= we_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; valid_q decides which slots
  // mean anything, so clearing the payload would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_q]   <= mdu_rd;
      data_mem[tail_q] <= mdu_data;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (valid_q[i]) pending[rd_mem[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign WE3        = we_q;
  assign A3         = a_q;
  assign WD3        = wd_q;
  assign alu_stall  = stall_q;
  assign fifo_count = count_q;

endmodule
